spi_response_transmitter: RTL
=============================

Name: spi_response_transmitter

Overview:
- SD-card SPI-mode response transmitter; the return path paired with the SPI command receiver.
- After the command decoder has produced a response, it shifts the response out on SPI_DO MSB-first.
- Changes DO only on SPI_CLK falling edges, so the host samples on rising edges (mode 0).
- Inserts the N_CR idle gap before the response, and handles R1, R1b (busy hold) and 40-bit R3/R7 responses.
- Runs in the system clock domain; SPI_CLK is oversampled.

Parameters:
- NCR_BYTES, 1, number of 0xFF bytes (all-ones bits) driven before the response; legal range 1..8.

Ports:
- clock  in  1  system clock; every SPI_CLK level is held for at least 1 clock period.
- reset  in  1  synchronous, active-low reset (0 = reset).
- io_SPI_CLK  in  1  SPI clock from the host, sampled.
- io_SPI_CS  in  1  chip select, active-low.
- io_SPI_DO  out  1  serial data to the host.
- io_Start  in  1  one-cycle request; accepted only when io_Ready=1 and io_SPI_CS=0.
- io_Type  in  2  response type: 0=R1 (8 bits), 1=R1b, 2=R3/R7 (40 bits); 3 is treated as R1.
- io_R1  in  8  R1 byte, captured on accepted start.
- io_Trailer  in  32  R3/R7 payload, captured on accepted start.
- io_Busy  in  1  card busy, used in the R1b busy phase only.
- io_Ready  out  1  high in IDLE.
- io_Done  out  1  one-cycle pulse when the response (including busy) completes.
- io____state  out  3  debug state encoding.

Behaviour:
- Reset (reset=0 at a clock edge): state IDLE, io_SPI_DO=1, io_Ready=1, io_Done=0, shift register=0, counters=0, clk_prev=0.
- Edge detect: clk_prev registers io_SPI_CLK each cycle. fall = clk_prev & ~io_SPI_CLK. All DO updates occur on the clock edge at which fall is true, i.e. 1 system clock after the sampled falling edge.
- States (encoding): IDLE=0, GAP=1, SEND=2, BUSY=3, DONE=4.
- IDLE:
  - DO=1.
  - On an accepted io_Start, load the shift register:
    - R1/R1b: {io_R1, 32'h0} with bit_cnt=8.
    - R3/R7: {io_R1, io_Trailer} with bit_cnt=40.
  - Set gap_cnt = NCR_BYTES*8 and latch the type; go to GAP.
  - A start while not ready, or while CS=1, is ignored.
- GAP: on each fall, DO=1 and gap_cnt-=1. When gap_cnt reaches 0, go to SEND; DO is not changed on that edge.
- SEND:
  - On each fall, DO = shreg[39], shift left by 1 (zero fill), bit_cnt-=1.
  - After the fall that outputs the last bit, stay in SEND with bit_cnt=0; the last bit stays on DO until the next fall.
  - On the fall with bit_cnt=0:
    - R1b: go to BUSY and drive DO = ~io_Busy.
    - Otherwise: DO=1 and go to DONE.
- BUSY: on each fall, DO = ~io_Busy. On a fall with io_Busy=0, DO=1 and go to DONE.
- DONE: io_Done=1 for exactly one clock, then IDLE. io_Ready=0 in DONE.
- CS abort: io_SPI_CS=1 in any non-IDLE state, at any clock, forces IDLE with DO=1. No io_Done pulse; the response is discarded. CS takes priority over fall in the same cycle.
- Response bits are sent MSB-first, with no CRC.
- DO never changes except on a fall edge, on reset, or on CS abort.

Decomposition:
- Shared SD package holds:
  - response type constants (RESP_R1=0, RESP_R1B=1, RESP_R37=2);
  - state encoding constants;
  - the SPI edge-detect helper as sub-module spi_clk_edge (registers SPI_CLK and outputs rise/fall), so the receiver can reuse it.
- Everything else stays in the single module.

Test Plan:
- After reset release, Start with Type=0, R1=0x01, NCR_BYTES=1: 8 falls give DO=1; the next 8 falls present 0,0,0,0,0,0,0,1; the following fall gives DO=1 and io_Done pulses for 1 clock; io_Ready=1 after that.
- Type=2, R1=0x01, Trailer=0x000001AA (CMD8 echo): after an 8-bit gap, 40 bits 0x01_000001AA MSB-first are sampled on rising edges; then Done.
- Type=1, R1=0x00, io_Busy=1 for 5 falls then 0: R1 byte, then DO=0 for 5 falls, then DO=1 and Done.
- CS raised to 1 mid-SEND after 3 bits: DO=1 the next clock; state IDLE; no Done; io_Ready=1. A new Start then works normally.
- Start pulsed again during GAP, and Start pulsed with CS=1 in IDLE: both are ignored; the transmitted bit stream is unchanged.
- reset=0 asserted mid-SEND: at the next clock edge DO=1, Ready=1, state=0, Done=0.

Source files
------------

// File: rtl/spi_response_transmitter_pkg.sv
// spi_response_transmitter_pkg: shared SD SPI response types, state encoding and helpers
package spi_response_transmitter_pkg;

    localparam logic [1:0] RESP_R1  = 2'd0;
    localparam logic [1:0] RESP_R1B = 2'd1;
    localparam logic [1:0] RESP_R37 = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_SEND = 3'd2,
        ST_BUSY = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Response length in bits; anything other than R3/R7 is a single R1 byte
    function automatic logic [5:0] resp_bits(input logic [1:0] t);
        return (t == RESP_R37) ? 6'd40 : 6'd8;
    endfunction

endpackage

// File: rtl/spi_response_transmitter_spi_clk_edge.sv
// spi_clk_edge: oversampled SPI clock edge detector shared by receiver and transmitter
module spi_clk_edge (
    input  logic clock,
    input  logic reset,
    input  logic spi_clk_i,
    output logic rise_o,
    output logic fall_o
);

    logic clk_prev_q;

    // Previous sampled SPI clock level, cleared on reset
    always_ff @(posedge clock) begin
        if (!reset) clk_prev_q <= 1'b0;
        else        clk_prev_q <= spi_clk_i;
    end

    assign rise_o = ~clk_prev_q & spi_clk_i;
    assign fall_o = clk_prev_q & ~spi_clk_i;

endmodule

// File: rtl/spi_response_transmitter.sv
// spi_response_transmitter: shifts SD SPI-mode R1/R1b/R3/R7 responses out on DO after the N_CR gap
module spi_response_transmitter
    import spi_response_transmitter_pkg::*;
#(
    parameter int unsigned NCR_BYTES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_SPI_CLK,
    input  logic        io_SPI_CS,
    output logic        io_SPI_DO,
    input  logic        io_Start,
    input  logic [1:0]  io_Type,
    input  logic [7:0]  io_R1,
    input  logic [31:0] io_Trailer,
    input  logic        io_Busy,
    output logic        io_Ready,
    output logic        io_Done,
    output logic [2:0]  io____state
);

    state_t      state_q;
    logic        do_q;
    logic [39:0] shreg_q;
    logic [5:0]  bit_cnt_q;
    logic [6:0]  gap_cnt_q;
    logic [1:0]  type_q;
    logic        fall;

    spi_clk_edge u_edge (
        .clock     (clock),
        .reset     (reset),
        .spi_clk_i (io_SPI_CLK),
        .rise_o    (),
        .fall_o    (fall)
    );

    // Response FSM: DO only moves on SPI falling edges; CS high aborts any response
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            do_q      <= 1'b1;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            type_q    <= RESP_R1;
        end else if (io_SPI_CS && state_q != ST_IDLE) begin
            state_q <= ST_IDLE;
            do_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    do_q <= 1'b1;
                    if (io_Start && !io_SPI_CS) begin
                        shreg_q   <= (io_Type == RESP_R37) ? {io_R1, io_Trailer} : {io_R1, 32'h0};
                        bit_cnt_q <= resp_bits(io_Type);
                        gap_cnt_q <= 7'(NCR_BYTES * 8);
                        type_q    <= io_Type;
                        state_q   <= ST_GAP;
                    end
                end
                ST_GAP: if (fall) begin
                    do_q      <= 1'b1;
                    gap_cnt_q <= gap_cnt_q - 7'd1;
                    if (gap_cnt_q == 7'd1) state_q <= ST_SEND;
                end
                ST_SEND: if (fall) begin
                    if (bit_cnt_q != 6'd0) begin
                        do_q      <= shreg_q[39];
                        shreg_q   <= {shreg_q[38:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q - 6'd1;
                    end else if (type_q == RESP_R1B) begin
                        do_q    <= ~io_Busy;
                        state_q <= ST_BUSY;
                    end else begin
                        do_q    <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_BUSY: if (fall) begin
                    do_q <= ~io_Busy;
                    if (!io_Busy) state_q <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign io_SPI_DO   = do_q;
    assign io_Ready    = (state_q == ST_IDLE);
    assign io_Done     = (state_q == ST_DONE);
    assign io____state = state_q;

endmodule
